// File: rtl/xdma_pkg.sv
// Shared types for the xDMA finish handshake: the remote finish word, the
// buffered request record, AXI response codes and the sender FSM states.
package xdma_pkg;

    typedef logic [7:0]  xdma_id_t;
    typedef logic [31:0] xdma_addr_t;
    typedef logic [63:0] xdma_data_t;

    typedef struct packed {
        xdma_id_t dma_id;
        xdma_id_t from;
    } xdma_to_remote_finish_t;

    typedef struct packed {
        xdma_id_t   dma_id;
        xdma_addr_t addr;
        xdma_id_t   from;
    } finish_req_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ISSUE,
        FS_WAIT_B
    } fs_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered storage; full/empty derived from an
// occupancy counter so non-power-of-two depths work.
module fifo_v3 #(
    parameter type         dtype = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  dtype data_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);

    dtype            mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/xdma_finish_sender.sv
// Transmit side of the xDMA finish handshake: buffers finish requests and
// issues each as a single-beat AXI write, retrying on error responses.
module xdma_finish_sender
    import xdma_pkg::*;
#(
    parameter type         id_t         = xdma_id_t,
    parameter type         addr_t       = xdma_addr_t,
    parameter type         data_t       = xdma_data_t,
    parameter int unsigned ReqDepth     = 4,
    parameter int unsigned MaxRetry     = 3,
    parameter addr_t       FinishOffset = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  id_t         local_id_i,
    input  logic        finish_valid_i,
    output logic        finish_ready_o,
    input  id_t         finish_dma_id_i,
    input  addr_t       finish_addr_i,
    output logic        aw_valid_o,
    input  logic        aw_ready_i,
    output addr_t       aw_addr_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output data_t       w_data_o,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [1:0]  b_resp_i,
    output logic        busy_o,
    output logic [15:0] sent_cnt_o,
    output logic        error_o
);

    typedef struct packed {
        id_t dma_id;
        id_t from;
    } word_t;

    typedef struct packed {
        id_t   dma_id;
        addr_t addr;
        id_t   from;
    } req_t;

    localparam int unsigned       RetryW   = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetry);

    fs_state_e         state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [RetryW-1:0] retry_q, retry_d;
    addr_t             addr_q, addr_d;
    data_t             data_q, data_d;
    logic [15:0]       sent_q, sent_d;
    logic              error_q, error_d;

    req_t      push_req, head_req;
    word_t     head_word;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    axi_resp_e resp;

    assign push_req  = '{dma_id: finish_dma_id_i, addr: finish_addr_i, from: local_id_i};
    assign head_word = '{dma_id: head_req.dma_id, from: head_req.from};
    assign resp      = axi_resp_e'(b_resp_i);

    // Held low during reset so nothing is offered while the FIFO is being cleared.
    assign finish_ready_o = rst_ni & ~fifo_full;
    assign fifo_push      = finish_valid_i & finish_ready_o;

    fifo_v3 #(
        .dtype (req_t),
        .DEPTH (ReqDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (push_req),
        .data_o  (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        retry_d    = retry_q;
        addr_d     = addr_q;
        data_d     = data_q;
        sent_d     = sent_q;
        error_d    = error_q;
        fifo_pop   = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                // Head stays in the FIFO until its B arrives; only a copy is issued.
                if (!fifo_empty) begin
                    state_d   = FS_ISSUE;
                    addr_d    = head_req.addr + FinishOffset;
                    data_d    = data_t'(head_word);
                    retry_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            FS_ISSUE: begin
                aw_valid_o = ~aw_done_q;
                w_valid_o  = ~w_done_q;
                aw_done_d  = aw_done_q | aw_ready_i;
                w_done_d   = w_done_q | w_ready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = FS_WAIT_B;
                end
            end
            FS_WAIT_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    if (resp == AXI_RESP_SLVERR || resp == AXI_RESP_DECERR) begin
                        if (retry_q < RetryMax) begin
                            retry_d   = retry_q + 1'b1;
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                            state_d   = FS_ISSUE;
                        end else begin
                            fifo_pop = 1'b1;
                            error_d  = 1'b1;
                            state_d  = FS_IDLE;
                        end
                    end else begin
                        fifo_pop = 1'b1;
                        sent_d   = sent_q + 16'd1;
                        state_d  = FS_IDLE;
                    end
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FS_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            retry_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            sent_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sent_q    <= sent_d;
            error_q   <= error_d;
        end
    end

    assign aw_addr_o  = addr_q;
    assign w_data_o   = data_q;
    assign busy_o     = ~fifo_empty | (state_q != FS_IDLE);
    assign sent_cnt_o = sent_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Bench for xdma_finish_sender: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the sender.
`timescale 1ns/1ps
module tb_xdma_finish_sender;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXR  = 3;
    localparam logic [31:0] OFF   = 32'h40;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [7:0]  local_id_i;
    logic        finish_valid_i;
    logic        finish_ready_o;
    logic [7:0]  finish_dma_id_i;
    logic [31:0] finish_addr_i;
    logic        aw_valid_o, aw_ready_i;
    logic [31:0] aw_addr_o;
    logic        w_valid_o, w_ready_i;
    logic [63:0] w_data_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        busy_o;
    logic [15:0] sent_cnt_o;
    logic        error_o;

    xdma_finish_sender #(
        .ReqDepth     (DEPTH),
        .MaxRetry     (MAXR),
        .FinishOffset (OFF)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .local_id_i      (local_id_i),
        .finish_valid_i  (finish_valid_i),
        .finish_ready_o  (finish_ready_o),
        .finish_dma_id_i (finish_dma_id_i),
        .finish_addr_i   (finish_addr_i),
        .aw_valid_o      (aw_valid_o),
        .aw_ready_i      (aw_ready_i),
        .aw_addr_o       (aw_addr_o),
        .w_valid_o       (w_valid_o),
        .w_ready_i       (w_ready_i),
        .w_data_o        (w_data_o),
        .b_valid_i       (b_valid_i),
        .b_ready_o       (b_ready_o),
        .b_resp_i        (b_resp_i),
        .busy_o          (busy_o),
        .sent_cnt_o      (sent_cnt_o),
        .error_o         (error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AXI slave knobs
    int         p_aw = 100, p_w = 100, p_b = 100;
    bit         aw_block = 1'b0, rand_resp = 1'b0;
    logic [1:0] script[$];

    initial begin
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b0;
        b_resp_i   = 2'b00;
        forever begin
            @(posedge clk_i); #1;
            aw_ready_i = !aw_block && ($urandom_range(0, 99) < p_aw);
            w_ready_i  = ($urandom_range(0, 99) < p_w);
            b_valid_i  = ($urandom_range(0, 99) < p_b);
            if (script.size() != 0)
                b_resp_i = script[0];
            else if (rand_resp && $urandom_range(0, 3) == 0)
                b_resp_i = 2'($urandom_range(1, 3));
            else
                b_resp_i = 2'b00;
        end
    end

    always @(negedge clk_i)
        if (rst_ni && b_valid_i && b_ready_o && script.size() != 0) void'(script.pop_front());

    // Transaction-level model: queue of accepted requests, one attempt in flight.
    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  from;
    } mreq_t;

    mreq_t mq[$];
    bit    m_active, m_aw, m_w, m_err;
    int    m_retry, m_sent, aw_hs;
    bit    e_aw, e_w, e_b, e_rdy, start;

    initial begin
        m_active = 0; m_aw = 0; m_w = 0; m_err = 0;
        m_retry = 0; m_sent = 0; aw_hs = 0;
    end

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mq.delete();
            m_active = 0; m_aw = 0; m_w = 0; m_err = 0; m_retry = 0; m_sent = 0;
        end else begin
            e_aw  = m_active && !m_aw;
            e_w   = m_active && !m_w;
            e_b   = m_active && m_aw && m_w;
            e_rdy = mq.size() < DEPTH;
            chk("finish_ready", 64'(finish_ready_o), 64'(e_rdy));
            chk("busy", 64'(busy_o), 64'(mq.size() != 0));
            chk("aw_valid", 64'(aw_valid_o), 64'(e_aw));
            chk("w_valid", 64'(w_valid_o), 64'(e_w));
            chk("b_ready", 64'(b_ready_o), 64'(e_b));
            chk("sent_cnt", 64'(sent_cnt_o), 64'(m_sent % 65536));
            chk("error", 64'(error_o), 64'(m_err));
            if (e_aw) chk("aw_addr", 64'(aw_addr_o), 64'(32'(mq[0].addr + OFF)));
            if (e_w)  chk("w_data", w_data_o, 64'(mq[0].id) * 256 + 64'(mq[0].from));

            start = !m_active && mq.size() != 0;
            if (e_aw && aw_ready_i) begin m_aw = 1; aw_hs++; end
            if (e_w && w_ready_i) m_w = 1;
            if (e_b && b_valid_i) begin
                if (!b_resp_i[1]) begin
                    void'(mq.pop_front()); m_sent++; m_active = 0;
                end else if (m_retry < int'(MAXR)) begin
                    m_retry++; m_aw = 0; m_w = 0;
                end else begin
                    void'(mq.pop_front()); m_err = 1; m_active = 0;
                end
            end
            if (start) begin m_active = 1; m_retry = 0; m_aw = 0; m_w = 0; end
            if (finish_valid_i && e_rdy)
                mq.push_back('{id: finish_dma_id_i, addr: finish_addr_i, from: local_id_i});
        end
    end

    task automatic push_req(input logic [7:0] id, input logic [31:0] a, input logic [7:0] lid);
        bit ok;
        @(posedge clk_i); #1;
        finish_valid_i = 1'b1; finish_dma_id_i = id; finish_addr_i = a; local_id_i = lid;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (finish_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("push_timeout", 64'(0), 64'(1));
        @(posedge clk_i); #1;
        finish_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (!busy_o && !finish_valid_i) begin ok = 1; break; end
        end
        if (!ok) chk(name, 64'(0), 64'(1));
    endtask

    int base;

    initial begin
        finish_valid_i = 0; finish_dma_id_i = 0; finish_addr_i = 0; local_id_i = 0;
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_aw_valid", 64'(aw_valid_o), 64'(0));
        chk("rst_w_valid", 64'(w_valid_o), 64'(0));
        chk("rst_b_ready", 64'(b_ready_o), 64'(0));
        chk("rst_finish_ready", 64'(finish_ready_o), 64'(0));
        chk("rst_sent", 64'(sent_cnt_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // 1: single request, everything ready, latency and packing pinned
        @(posedge clk_i); #1;
        finish_valid_i = 1; finish_dma_id_i = 8'd5; finish_addr_i = 32'h1000; local_id_i = 8'd2;
        @(negedge clk_i);
        chk("t1_ready", 64'(finish_ready_o), 64'(1));
        @(posedge clk_i); #1 finish_valid_i = 0;
        @(negedge clk_i);
        chk("t1_lat_n1", 64'(aw_valid_o), 64'(0));
        @(negedge clk_i);
        chk("t1_lat_n2", 64'(aw_valid_o), 64'(1));
        chk("t1_aw_addr", 64'(aw_addr_o), 64'h1040);
        chk("t1_w_data", w_data_o, 64'h0502);
        @(negedge clk_i);
        chk("t1_b_ready", 64'(b_ready_o), 64'(1));
        @(negedge clk_i);
        chk("t1_busy_after_b", 64'(busy_o), 64'(0));
        chk("t1_sent", 64'(sent_cnt_o), 64'(1));

        // 2: AW stalled, W goes first
        aw_block = 1;
        push_req(8'h11, 32'h2000, 8'h3);
        repeat (10) @(negedge clk_i);
        chk("t2_w_taken", 64'(w_valid_o), 64'(0));
        chk("t2_aw_held", 64'(aw_valid_o), 64'(1));
        aw_block = 0;
        wait_idle("t2_idle_timeout");
        chk("t2_sent", 64'(sent_cnt_o), 64'(2));

        // 3: fill the FIFO behind a blocked AW, then drain
        aw_block = 1;
        for (int i = 0; i < DEPTH; i++) push_req(8'(8'h20 + i), 32'(32'h3000 + i * 16), 8'h4);
        @(negedge clk_i);
        chk("t3_full", 64'(finish_ready_o), 64'(0));
        fork
            push_req(8'h2F, 32'h3FF0, 8'h4);
            begin repeat (6) @(posedge clk_i); #1 aw_block = 0; end
        join
        wait_idle("t3_idle_timeout");
        chk("t3_sent", 64'(sent_cnt_o), 64'(7));

        // 4: two SLVERR then OKAY
        base = aw_hs;
        script = '{2'b10, 2'b10, 2'b00};
        push_req(8'h33, 32'h4000, 8'h5);
        wait_idle("t4_idle_timeout");
        chk("t4_aw_issues", 64'(aw_hs - base), 64'(3));
        chk("t4_sent", 64'(sent_cnt_o), 64'(8));
        chk("t4_error", 64'(error_o), 64'(0));

        // 5: DECERR beyond the retry limit drops the head, next is still sent
        base = aw_hs;
        script = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        push_req(8'h44, 32'h5000, 8'h6);
        push_req(8'h45, 32'h5100, 8'h6);
        wait_idle("t5_idle_timeout");
        chk("t5_aw_issues", 64'(aw_hs - base), 64'(5));
        chk("t5_sent", 64'(sent_cnt_o), 64'(9));
        chk("t5_error", 64'(error_o), 64'(1));

        // 6: reset while waiting for B
        p_b = 0;
        push_req(8'h55, 32'h6000, 8'h7);
        push_req(8'h56, 32'h6100, 8'h7);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_i);
                if (b_ready_o) begin ok = 1; break; end
            end
            chk("t6_reach_wait_b", 64'(ok), 64'(1));
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_aw_valid", 64'(aw_valid_o), 64'(0));
        chk("t6_w_valid", 64'(w_valid_o), 64'(0));
        chk("t6_b_ready", 64'(b_ready_o), 64'(0));
        chk("t6_busy", 64'(busy_o), 64'(0));
        chk("t6_sent", 64'(sent_cnt_o), 64'(0));
        chk("t6_error", 64'(error_o), 64'(0));
        script.delete();
        p_b = 100;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6_ready_after", 64'(finish_ready_o), 64'(1));

        // randomized traffic, random stalls and responses
        p_aw = 70; p_w = 70; p_b = 60; rand_resp = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i); #1;
            finish_valid_i  = ($urandom_range(0, 99) < 20);
            finish_dma_id_i = 8'($urandom);
            local_id_i      = 8'($urandom);
            finish_addr_i   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63))
                                                          : 32'($urandom);
        end
        @(posedge clk_i); #1 finish_valid_i = 0;
        wait_idle("rand_idle_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
